// File: rtl/ebus_pkg.sv
// Shared EBUS definitions: function codes, FSM states and function-class helpers.
package ebus_pkg;

  typedef logic [2:0] ebus_func_t;

  localparam ebus_func_t EBUS_CONO  = 3'd0;
  localparam ebus_func_t EBUS_CONI  = 3'd1;
  localparam ebus_func_t EBUS_DATAO = 3'd2;
  localparam ebus_func_t EBUS_DATAI = 3'd3;

  localparam int CNT_W = 10;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    DEMAND,
    RELEASE
  } ebus_state_t;

  function automatic logic ebus_is_legal(input ebus_func_t f);
    return f < 3'd4;
  endfunction

  function automatic logic ebus_is_write(input ebus_func_t f);
    return (f == EBUS_CONO) || (f == EBUS_DATAO);
  endfunction

endpackage

// File: rtl/ebus_sync.sv
// N-stage synchronizer with asynchronous active-low clear.
module ebus_sync #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [N-1:0] r_sync;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= '0;
    else        r_sync <= {r_sync[N-2:0], i_d};
  end

  assign o_q = r_sync[N-1];

endmodule

// File: rtl/ebus_master.sv
// EBOX-side EBUS initiator: one CONO/CONI/DATAO/DATAI transaction at a time,
// DEMAND/XFER handshake with bounded waits and a timeout error report.
module ebus_master
  import ebus_pkg::*;
#(
  parameter int SETUP_CYC   = 2,
  parameter int TIMEOUT_CYC = 255,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        RESET_L,
  input  logic        REQ,
  input  logic [0:2]  REQ_FUNC,
  input  logic [0:6]  REQ_CS,
  input  logic [0:35] REQ_DATA,
  output logic        BUSY,
  output logic        DONE,
  output logic        TIMEOUT_ERR,
  output logic [0:35] RD_DATA,
  output logic [0:6]  EBUS_CS,
  output logic [0:2]  EBUS_FUNC,
  output logic        EBUS_DEMAND,
  output logic [0:35] EBUS_DATA_OUT,
  output logic        EBUS_DATA_OE,
  input  logic        EBUS_XFER,
  input  logic [0:35] EBUS_DATA_IN
);

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYC - 1);

  ebus_state_t      r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_xfer_q, r_err, r_busy, r_done, r_timeout_err, r_demand, r_oe;
  logic [0:6]       r_cs;
  ebus_func_t       r_func;
  logic [0:35]      r_data_out, r_rd_data;

  logic       w_xfer_s, w_xfer_rise;
  ebus_func_t w_func;
  logic       w_accept, w_illegal, w_demand_on, w_stuck, w_rise_hit;
  logic       w_dem_to, w_rel_to, w_finish;

  ebus_sync #(.N(SYNC_STAGES)) u_xfer_sync (
    .clk   (clk),
    .rst_n (RESET_L),
    .i_d   (EBUS_XFER),
    .o_q   (w_xfer_s)
  );

  assign w_func      = REQ_FUNC;
  assign w_xfer_rise = w_xfer_s & ~r_xfer_q;

  always_ff @(posedge clk or negedge RESET_L) begin
    if (!RESET_L) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_illegal   = 1'b0;
    w_demand_on = 1'b0;
    w_stuck     = 1'b0;
    w_rise_hit  = 1'b0;
    w_dem_to    = 1'b0;
    w_rel_to    = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      IDLE: begin
        // A REQ still held during the DONE cycle belongs to the finished transaction.
        if (REQ && !r_done) begin
          if (ebus_is_legal(w_func)) begin
            w_accept    = 1'b1;
            w_state_nxt = SETUP;
          end else begin
            w_illegal = 1'b1;
          end
        end
      end
      SETUP: begin
        if (r_cnt == SETUP_LAST) begin
          if (w_xfer_s) begin
            w_stuck     = 1'b1;
            w_state_nxt = RELEASE;
          end else begin
            w_demand_on = 1'b1;
            w_state_nxt = DEMAND;
          end
        end
      end
      DEMAND: begin
        if (w_xfer_rise) begin
          w_rise_hit  = 1'b1;
          w_state_nxt = RELEASE;
        end else if (r_cnt == TO_LAST) begin
          w_dem_to    = 1'b1;
          w_state_nxt = RELEASE;
        end
      end
      RELEASE: begin
        if (!w_xfer_s) begin
          w_finish    = 1'b1;
          w_state_nxt = IDLE;
        end else if (r_cnt == TO_LAST) begin
          w_finish    = 1'b1;
          w_rel_to    = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge RESET_L) begin
    if (!RESET_L) begin
      r_cnt         <= '0;
      r_xfer_q      <= 1'b0;
      r_err         <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_timeout_err <= 1'b0;
      r_demand      <= 1'b0;
      r_oe          <= 1'b0;
      r_cs          <= '0;
      r_func        <= '0;
      r_data_out    <= '0;
      r_rd_data     <= '0;
    end else begin
      r_xfer_q      <= w_xfer_s;
      r_done        <= w_finish | w_illegal;
      r_timeout_err <= w_illegal | (w_finish & (r_err | w_rel_to));

      // Each wait state starts a fresh count; saturation keeps a long wait from wrapping.
      if (r_state == IDLE || w_state_nxt != r_state) r_cnt <= '0;
      else if (r_cnt != '1)                          r_cnt <= r_cnt + 1'b1;

      if (w_accept)                              r_err <= 1'b0;
      else if (w_stuck || w_dem_to || w_rel_to) r_err <= 1'b1;

      if (w_demand_on)                r_demand <= 1'b1;
      else if (w_rise_hit || w_dem_to) r_demand <= 1'b0;

      if (w_rise_hit && !ebus_is_write(r_func)) r_rd_data <= EBUS_DATA_IN;

      if (w_accept) begin
        r_busy     <= 1'b1;
        r_oe       <= ebus_is_write(w_func);
        r_cs       <= REQ_CS;
        r_func     <= w_func;
        r_data_out <= REQ_DATA;
      end else if (w_finish) begin
        r_busy <= 1'b0;
        r_oe   <= 1'b0;
        r_cs   <= '0;
        r_func <= '0;
      end
    end
  end

  assign BUSY          = r_busy;
  assign DONE          = r_done;
  assign TIMEOUT_ERR   = r_timeout_err;
  assign RD_DATA       = r_rd_data;
  assign EBUS_CS       = r_cs;
  assign EBUS_FUNC     = r_func;
  assign EBUS_DEMAND   = r_demand;
  assign EBUS_DATA_OUT = r_data_out;
  assign EBUS_DATA_OE  = r_oe;

endmodule
